lvds_ctrl_panel: RTL
====================

Name: lvds_ctrl_panel

Overview:
- Operator-control front end directly upstream of the HSMC differential PWM driver.
- Debounces the four SoCKit pushbuttons and turns presses into a 4-bit duty code and a 4-bit lane data pattern; in switch mode the duty code follows SW instead.
- Holds pending settings in shadow registers and commits them only on the driver's frame_start pulse, so a PWM period never changes mid-cycle.

Parameters:
- DEBOUNCE_CYCLES, 1000000, clock cycles a key must be stable before accepted (20 ms at 50 MHz); must be >= 2.
- RESET_DUTY, 8, duty code loaded at reset (0..15).
- RESET_DATA, 4'b1111, lane data pattern loaded at reset.

Ports:
- OSC_50_B8A  input  1  50 MHz clock; single clock domain.
- RESET_n  input  1  asynchronous active-low reset.
- KEY  input  4  raw pushbuttons, active-low, asynchronous. KEY[0] duty down, KEY[1] duty up, KEY[2] data pattern +1, KEY[3] mode toggle.
- SW  input  4  raw slide switches, asynchronous; duty source in switch mode.
- frame_start  input  1  one-cycle pulse from the PWM driver at timer wrap.
- duty_code  output  4  committed duty code; driver computes on-time as CYCLE*duty_code/16.
- data  output  4  committed lane pattern for the HSMC TX pairs.
- mode  output  1  committed mode: 0 manual (keys), 1 switch (SW).
- upd  output  1  one-cycle pulse: committed values changed.
- LED  output  4  status: duty_code in manual mode, data in switch mode.

Behaviour:
- Reset (RESET_n low, asynchronous): synchronizers load 1 for KEY and 0 for SW. Debounced key state is 4'b1111 and debounce counters are 0. Shadow and committed duty = RESET_DUTY, data = RESET_DATA, mode = 0. upd = 0 and LED = RESET_DUTY. Reset deassertion is synchronized: two-flop release.
- Synchronization: KEY and SW each pass through two flops before any use.
- Debounce, per key, independent:
  - Counter clears whenever the synced input equals the stable state.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, stable takes the synced value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES is never accepted.
- Press event: one-cycle pulse on the cycle after stable goes 1->0. Release produces no event. Holding a key gives exactly one event (no auto-repeat).
- Shadow update, on the cycle of the event:
  - KEY[0]: duty -1, saturating at 0.
  - KEY[1]: duty +1, saturating at 15.
  - Both KEY[0] and KEY[1] events in the same cycle: duty unchanged.
  - KEY[2]: data +1, wraps 15->0.
  - KEY[3]: mode inverts.
  - In mode 1, KEY[0] and KEY[1] are ignored, and the shadow duty loads the synced SW every cycle.
  - Switching 1->0 keeps the last SW-derived duty as the manual starting point.
- Commit:
  - On a cycle with frame_start=1, committed duty_code, data and mode load from the shadow values as they stood at the start of that cycle. The new values are visible on the next cycle.
  - An event coinciding with frame_start updates the shadow only; it commits at the following frame_start.
  - Without frame_start, outputs never change (except via reset).
- upd: asserted in the same cycle the new committed values first appear, and only if at least one committed field differs from its prior value. Otherwise it stays 0.
- LED: combinational from the committed outputs.
- Reset mid-debounce or with a pending shadow change: everything returns to reset values; the pending change is lost.
- All outputs are registered except LED.

Test Plan:
- Reset, DEBOUNCE_CYCLES=4, pulse frame_start -> duty_code=8, data=4'b1111, mode=0, upd=0, LED=8.
- Hold KEY[1] low 10 cycles, then frame_start -> exactly one increment, duty_code=9, upd=1 for one cycle; an earlier 3-cycle KEY[1] glitch must cause no change.
- Eight KEY[1] presses from duty 8, then frame_start -> duty_code=15 (saturates at 15); 16 KEY[0] presses, then frame_start -> 0; press KEY[0] and KEY[1] together -> unchanged.
- KEY[2] pressed 16 times from 4'b1111, frame_start after each -> data sequence 0,1,…,15, wrapping correctly, upd each time.
- KEY[3] press, SW=4'b0011, frame_start -> mode=1, duty_code=3, LED=data; KEY[1] press -> no effect; KEY[3] again with SW=5, frame_start -> mode=0, duty_code=5.
- KEY[1] event on the same cycle as frame_start -> duty_code unchanged after it; next frame_start -> duty_code+1. Assert RESET_n mid-debounce -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/lvds_ctrl_panel.sv
// Operator front end for the HSMC PWM driver: debounced keys and switches drive
// shadow settings that are committed only on the driver's frame_start pulse.
module lvds_ctrl_panel #(
    parameter int         DEBOUNCE_CYCLES = 1000000,
    parameter logic [3:0] RESET_DUTY      = 4'd8,
    parameter logic [3:0] RESET_DATA      = 4'b1111
) (
    input  logic       OSC_50_B8A,
    input  logic       RESET_n,
    input  logic [3:0] KEY,
    input  logic [3:0] SW,
    input  logic       frame_start,
    output logic [3:0] duty_code,
    output logic [3:0] data,
    output logic       mode,
    output logic       upd,
    output logic [3:0] LED
);
    localparam int             CW      = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          clk;
    logic [1:0]    rst_ff;
    logic          rst_n;
    logic [3:0]    key_s1, key_s2, sw_s1, sw_s2;
    logic [3:0]    key_stable, key_prev, press;
    logic [CW-1:0] cnt [4];
    logic [3:0]    duty_sh, data_sh, duty_nx, data_nx;
    logic          mode_sh, mode_nx;

    assign clk = OSC_50_B8A;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clk or negedge RESET_n) begin
        if (!RESET_n) rst_ff <= 2'b00;
        else          rst_ff <= {rst_ff[0], 1'b1};
    end
    assign rst_n = rst_ff[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 4'b1111;
            key_s2 <= 4'b1111;
            sw_s1  <= 4'b0000;
            sw_s2  <= 4'b0000;
        end else begin
            key_s1 <= KEY;
            key_s2 <= key_s1;
            sw_s1  <= SW;
            sw_s2  <= sw_s1;
        end
    end

    // A key is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_stable <= 4'b1111;
            key_prev   <= 4'b1111;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            key_prev <= key_stable;
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] == key_stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    key_stable[i] <= key_s2[i];
                    cnt[i]        <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = key_prev & ~key_stable;

    always_comb begin
        duty_nx = duty_sh;
        data_nx = data_sh;
        mode_nx = mode_sh;
        if (mode_sh) begin
            duty_nx = sw_s2;
        end else if (press[0] && !press[1]) begin
            duty_nx = (duty_sh == 4'd0) ? 4'd0 : duty_sh - 4'd1;
        end else if (press[1] && !press[0]) begin
            duty_nx = (duty_sh == 4'd15) ? 4'd15 : duty_sh + 4'd1;
        end
        if (press[2]) data_nx = data_sh + 4'd1;
        if (press[3]) mode_nx = ~mode_sh;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_sh <= RESET_DUTY;
            data_sh <= RESET_DATA;
            mode_sh <= 1'b0;
        end else begin
            duty_sh <= duty_nx;
            data_sh <= data_nx;
            mode_sh <= mode_nx;
        end
    end

    // Commit samples the shadow as it stood before any same-cycle key event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_code <= RESET_DUTY;
            data      <= RESET_DATA;
            mode      <= 1'b0;
            upd       <= 1'b0;
        end else begin
            upd <= frame_start &&
                   ({duty_sh, data_sh, mode_sh} != {duty_code, data, mode});
            if (frame_start) begin
                duty_code <= duty_sh;
                data      <= data_sh;
                mode      <= mode_sh;
            end
        end
    end

    assign LED = mode ? data : duty_code;

endmodule
